rggen_bus_slice: RTL and testbench
==================================

RGGEN_BUS_SLICE -- requirements
Module: rggen_bus_slice

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 16, the bus address width.
REQ-002 SHALL have parameter BUS_WIDTH, default 32, the data width.
REQ-003 SHALL have parameter STROBE_WIDTH, default BUS_WIDTH/8, the strobe width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 256, the timeout limit; used only when the timeout is compiled in.
REQ-005 SHALL have port i_clk, input, 1, the single clock; all state is sampled on its rising edge.
REQ-006 SHALL have port i_rst_n, input, 1, the reset: asynchronous, active-low.
REQ-007 SHALL have port slave_if, rggen_bus_if.slave modport, parameterised width, upstream side facing the host adapter.
REQ-008 SHALL have port master_if, rggen_bus_if.master modport, parameterised width, downstream side facing the register block.

Function
REQ-009 SHALL be a non-pipelined register slice with three states: IDLE, REQUEST and RESPONSE.
REQ-010 In IDLE with slave_if.valid=1, it SHALL capture access, address, write_data and strobe into registers and go to REQUEST.
REQ-011 In REQUEST it SHALL drive master_if.valid=1 and drive the captured fields, unchanged, onto master_if.
REQ-012 In REQUEST with master_if.ready=1, it SHALL capture status and read_data and go to RESPONSE; master_if.valid SHALL drop in the following cycle.
REQ-013 In RESPONSE it SHALL assert slave_if.ready for exactly one cycle, with the captured status and read_data, then go to IDLE.
REQ-014 Latency: upstream valid sampled in cycle N gives master_if.valid in N+1; downstream ready in cycle M gives slave_if.ready in M+1.
REQ-015 slave_if.valid still high during the RESPONSE cycle SHALL NOT be re-accepted; only valid sampled in IDLE starts a transaction.
REQ-016 master_if.ready outside REQUEST SHALL be ignored, with no state or data change.
REQ-017 slave_if.read_data and slave_if.status SHALL hold their last captured values outside RESPONSE.
REQ-018 master_if.address, write_data, strobe and access SHALL hold their values outside REQUEST.
REQ-019 Changes on upstream fields after capture SHALL NOT affect the downstream fields.

Reset
REQ-020 On i_rst_n=0 the state SHALL go to IDLE immediately, without waiting for a clock edge.
REQ-021 On i_rst_n=0, master_if.valid and slave_if.ready SHALL go to 0.
REQ-022 On i_rst_n=0, address, write_data, strobe and read_data registers SHALL go to all-zero; access SHALL go to RGGEN_READ; status SHALL go to RGGEN_OKAY.
REQ-023 Reset asserted mid-transaction SHALL abandon that transaction with no response; the first valid after reset release SHALL start a new transaction.

Configuration
REQ-024 Macro RGGEN_BUS_SLICE_TIMEOUT_EN SHALL enable a request timeout.
REQ-025 With the macro defined, a counter SHALL clear on entry to REQUEST and increment on each REQUEST cycle without master_if.ready.
REQ-026 With the macro defined, when the count reaches TIMEOUT_CYCLES-1 without ready, the slice SHALL drop master_if.valid, load status=RGGEN_SLAVE_ERROR and read_data=0, and go to RESPONSE.
REQ-027 With the macro defined, master_if.ready in the same cycle as expiry SHALL take priority, giving a normal completion.
REQ-028 With the macro defined, the counter width SHALL be clog2(TIMEOUT_CYCLES), minimum 1 bit.
REQ-029 Without the macro, no counter logic SHALL exist and REQUEST SHALL wait indefinitely; TIMEOUT_CYCLES is ignored.

Verification
REQ-030 Write addr=0x0010, data=0xDEADBEEF, strobe=0xF; downstream ready one cycle after valid -> downstream sees identical fields; upstream ready exactly 1 cycle, status=RGGEN_OKAY.
REQ-031 Read addr=0x0020; downstream returns 0x12345678 with RGGEN_SLAVE_ERROR after 5 cycles -> upstream ready 1 cycle later, read_data=0x12345678, status=RGGEN_SLAVE_ERROR.
REQ-032 Back-to-back reads, upstream valid held high continuously -> exactly two downstream transactions, the second starting from IDLE after the RESPONSE cycle.
REQ-033 Stray master_if.ready pulses in IDLE and RESPONSE -> no state change and no extra upstream ready.
REQ-034 i_rst_n pulled low mid-REQUEST, asynchronously between edges -> master_if.valid=0 immediately; after release the next request completes normally.
REQ-035 With RGGEN_BUS_SLICE_TIMEOUT_EN and TIMEOUT_CYCLES=8, no downstream ready -> valid drops after 8 REQUEST cycles; upstream gets RGGEN_SLAVE_ERROR with read_data=0; ready on the 8th cycle -> normal completion.

Source files
------------

// File: rtl/rggen_bus_slice_if.sv
// ---------------------------------------------------------------------------
// rggen_bus_pkg / rggen_bus_if
//
// Purpose : Shared access/status encodings and the simple valid/ready
//           register bus used between a host adapter and a register block.
//
// Interface signals:
//   valid      - request valid (master -> slave)
//   access     - access kind, rggen_access (master -> slave)
//   address    - byte address, ADDRESS_WIDTH bits (master -> slave)
//   write_data - write data, BUS_WIDTH bits (master -> slave)
//   strobe     - byte enables, STROBE_WIDTH bits (master -> slave)
//   ready      - response valid, one cycle per request (slave -> master)
//   status     - response status, rggen_status (slave -> master)
//   read_data  - read data, BUS_WIDTH bits (slave -> master)
// ---------------------------------------------------------------------------
package rggen_bus_pkg;

    typedef enum logic [1:0] {
        RGGEN_READ         = 2'b00,
        RGGEN_POSTED_WRITE = 2'b01,
        RGGEN_WRITE        = 2'b11
    } rggen_access;

    typedef enum logic [1:0] {
        RGGEN_OKAY         = 2'b00,
        RGGEN_EXOKAY       = 2'b01,
        RGGEN_SLAVE_ERROR  = 2'b10,
        RGGEN_DECODE_ERROR = 2'b11
    } rggen_status;

endpackage

interface rggen_bus_if #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int BUS_WIDTH     = 32,
    parameter int STROBE_WIDTH  = BUS_WIDTH / 8
);

    logic                           valid;
    rggen_bus_pkg::rggen_access     access;
    logic [ADDRESS_WIDTH-1:0]       address;
    logic [BUS_WIDTH-1:0]           write_data;
    logic [STROBE_WIDTH-1:0]        strobe;
    logic                           ready;
    rggen_bus_pkg::rggen_status     status;
    logic [BUS_WIDTH-1:0]           read_data;

    modport master (
        output valid, access, address, write_data, strobe,
        input  ready, status, read_data
    );

    modport slave (
        input  valid, access, address, write_data, strobe,
        output ready, status, read_data
    );

endinterface

// File: rtl/rggen_bus_slice.sv
// ---------------------------------------------------------------------------
// rggen_bus_slice
//
// Purpose : Non-pipelined register slice between a host adapter (upstream)
//           and a register block (downstream). One transaction is in flight
//           at a time: IDLE captures the request, REQUEST presents it
//           downstream, RESPONSE returns the captured answer upstream for
//           exactly one cycle.
//
// Ports:
//   i_clk     - clock, rising edge
//   i_rst_n   - asynchronous active-low reset
//   slave_if  - rggen_bus_if.slave, upstream side facing the host adapter
//   master_if - rggen_bus_if.master, downstream side facing the register block
//
// Build option:
//   RGGEN_BUS_SLICE_TIMEOUT_EN - when defined, a REQUEST that sees no
//   downstream ready for TIMEOUT_CYCLES cycles is completed locally with
//   RGGEN_SLAVE_ERROR and zero read data. When undefined, REQUEST waits
//   indefinitely and TIMEOUT_CYCLES has no effect.
// ---------------------------------------------------------------------------
module rggen_bus_slice
    import rggen_bus_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = 16,
    parameter int BUS_WIDTH      = 32,
    parameter int STROBE_WIDTH   = BUS_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 256
) (
    input logic         i_clk,
    input logic         i_rst_n,
    rggen_bus_if.slave  slave_if,
    rggen_bus_if.master master_if
);

    typedef enum logic [1:0] {
        IDLE,
        REQUEST,
        RESPONSE
    } state_e;

    state_e                     state_q,      state_d;
    rggen_access                access_q,     access_d;
    logic [ADDRESS_WIDTH-1:0]   address_q,    address_d;
    logic [BUS_WIDTH-1:0]       write_data_q, write_data_d;
    logic [STROBE_WIDTH-1:0]    strobe_q,     strobe_d;
    rggen_status                status_q,     status_d;
    logic [BUS_WIDTH-1:0]       read_data_q,  read_data_d;

`ifdef RGGEN_BUS_SLICE_TIMEOUT_EN
    localparam int COUNT_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [COUNT_WIDTH-1:0] TIMEOUT_LIMIT = COUNT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [COUNT_WIDTH-1:0]     count_q,      count_d;
`endif

    // Next-state and capture logic. Request fields are only loaded in IDLE
    // and response fields only in REQUEST, so everything else holds.
    always_comb begin
        state_d      = state_q;
        access_d     = access_q;
        address_d    = address_q;
        write_data_d = write_data_q;
        strobe_d     = strobe_q;
        status_d     = status_q;
        read_data_d  = read_data_q;
`ifdef RGGEN_BUS_SLICE_TIMEOUT_EN
        count_d      = count_q;
`endif

        case (state_q)
            IDLE: begin
                if (slave_if.valid) begin
                    access_d     = slave_if.access;
                    address_d    = slave_if.address;
                    write_data_d = slave_if.write_data;
                    strobe_d     = slave_if.strobe;
                    state_d      = REQUEST;
`ifdef RGGEN_BUS_SLICE_TIMEOUT_EN
                    count_d      = '0;
`endif
                end
            end
            REQUEST: begin
                // A real downstream answer wins over an expiring timeout.
                if (master_if.ready) begin
                    status_d    = master_if.status;
                    read_data_d = master_if.read_data;
                    state_d     = RESPONSE;
                end
`ifdef RGGEN_BUS_SLICE_TIMEOUT_EN
                else if (count_q == TIMEOUT_LIMIT) begin
                    status_d    = RGGEN_SLAVE_ERROR;
                    read_data_d = '0;
                    state_d     = RESPONSE;
                end
                else begin
                    count_d = count_q + COUNT_WIDTH'(1);
                end
`endif
            end
            RESPONSE: begin
                // Upstream valid seen here is deliberately not accepted.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and data registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            access_q     <= RGGEN_READ;
            address_q    <= '0;
            write_data_q <= '0;
            strobe_q     <= '0;
            status_q     <= RGGEN_OKAY;
            read_data_q  <= '0;
        end
        else begin
            state_q      <= state_d;
            access_q     <= access_d;
            address_q    <= address_d;
            write_data_q <= write_data_d;
            strobe_q     <= strobe_d;
            status_q     <= status_d;
            read_data_q  <= read_data_d;
        end
    end

`ifdef RGGEN_BUS_SLICE_TIMEOUT_EN
    // Request timeout counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_q <= '0;
        end
        else begin
            count_q <= count_d;
        end
    end
`endif

    // Handshake outputs decode straight from the state register so that an
    // asynchronous reset drops them without waiting for a clock edge.
    assign master_if.valid      = (state_q == REQUEST);
    assign master_if.access     = access_q;
    assign master_if.address    = address_q;
    assign master_if.write_data = write_data_q;
    assign master_if.strobe     = strobe_q;

    assign slave_if.ready       = (state_q == RESPONSE);
    assign slave_if.status      = status_q;
    assign slave_if.read_data   = read_data_q;

endmodule

// File: tb/tb_rggen_bus_slice.sv
// ---------------------------------------------------------------------------
// tb_rggen_bus_slice
//
// Directed bench for rggen_bus_slice. Each scenario task drives the upstream
// and downstream sides by hand and compares DUT outputs with hand-computed
// values one time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_rggen_bus_slice;
    import rggen_bus_pkg::*;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic clk;
    logic rst_n;

    int n_compared;
    int n_mismatched;
    int n_handshakes;

    rggen_bus_if #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(DW), .STROBE_WIDTH(SW)) s_if ();
    rggen_bus_if #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(DW), .STROBE_WIDTH(SW)) m_if ();

    rggen_bus_slice #(
        .ADDRESS_WIDTH  (AW),
        .BUS_WIDTH      (DW),
        .STROBE_WIDTH   (SW),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .slave_if  (s_if),
        .master_if (m_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts completed downstream handshakes.
    always @(posedge clk) begin
        if (rst_n && m_if.valid && m_if.ready) n_handshakes++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_compared++;
        if (m_if.valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_m_valid: got %b expected 0", m_if.valid); end
        n_compared++;
        if (s_if.ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_s_ready: got %b expected 0", s_if.ready); end
        n_compared++;
        if (m_if.address !== 16'h0000) begin n_mismatched++; $display("[TB] FAIL reset_address: got %h expected 0000", m_if.address); end
        n_compared++;
        if (m_if.write_data !== 32'h0 || m_if.strobe !== 4'h0) begin n_mismatched++; $display("[TB] FAIL reset_wdata_strobe: got %h/%h expected 0/0", m_if.write_data, m_if.strobe); end
        n_compared++;
        if (m_if.access !== RGGEN_READ) begin n_mismatched++; $display("[TB] FAIL reset_access: got %h expected %h", m_if.access, RGGEN_READ); end
        n_compared++;
        if (s_if.status !== RGGEN_OKAY || s_if.read_data !== 32'h0) begin n_mismatched++; $display("[TB] FAIL reset_status_rdata: got %h/%h expected 0/0", s_if.status, s_if.read_data); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_write();
        s_if.valid      = 1'b1;
        s_if.access     = RGGEN_WRITE;
        s_if.address    = 16'h0010;
        s_if.write_data = 32'hDEADBEEF;
        s_if.strobe     = 4'hF;
        tick();
        // Upstream fields change after capture and must not leak through.
        s_if.valid      = 1'b0;
        s_if.access     = RGGEN_READ;
        s_if.address    = 16'hFFFF;
        s_if.write_data = 32'h0;
        s_if.strobe     = 4'h0;
        n_compared++;
        if (m_if.valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL write_m_valid: got %b expected 1", m_if.valid); end
        tick();
        n_compared++;
        if (m_if.valid !== 1'b1 || m_if.address !== 16'h0010 || m_if.write_data !== 32'hDEADBEEF
            || m_if.strobe !== 4'hF || m_if.access !== RGGEN_WRITE) begin
            n_mismatched++;
            $display("[TB] FAIL write_fields: got v=%b a=%h d=%h s=%h acc=%h expected v=1 a=0010 d=deadbeef s=f acc=3",
                     m_if.valid, m_if.address, m_if.write_data, m_if.strobe, m_if.access);
        end
        m_if.ready     = 1'b1;
        m_if.status    = RGGEN_OKAY;
        m_if.read_data = 32'h0;
        tick();
        m_if.ready = 1'b0;
        n_compared++;
        if (s_if.ready !== 1'b1 || s_if.status !== RGGEN_OKAY || m_if.valid !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL write_response: got rdy=%b st=%h mv=%b expected rdy=1 st=0 mv=0", s_if.ready, s_if.status, m_if.valid);
        end
        tick();
        n_compared++;
        if (s_if.ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL write_ready_once: got %b expected 0", s_if.ready); end
        n_compared++;
        if (m_if.address !== 16'h0010 || m_if.write_data !== 32'hDEADBEEF) begin n_mismatched++; $display("[TB] FAIL write_hold: got %h/%h expected 0010/deadbeef", m_if.address, m_if.write_data); end
    endtask

    task automatic test_read_slow();
        s_if.valid   = 1'b1;
        s_if.access  = RGGEN_READ;
        s_if.address = 16'h0020;
        tick();
        s_if.valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_compared++;
            if (m_if.valid !== 1'b1 || s_if.ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL read_wait_%0d: got mv=%b sr=%b expected mv=1 sr=0", i, m_if.valid, s_if.ready); end
            tick();
        end
        n_compared++;
        if (m_if.address !== 16'h0020 || m_if.access !== RGGEN_READ) begin n_mismatched++; $display("[TB] FAIL read_fields: got %h/%h expected 0020/0", m_if.address, m_if.access); end
        m_if.ready     = 1'b1;
        m_if.status    = RGGEN_SLAVE_ERROR;
        m_if.read_data = 32'h12345678;
        tick();
        m_if.ready     = 1'b0;
        m_if.status    = RGGEN_OKAY;
        m_if.read_data = 32'h0;
        n_compared++;
        if (s_if.ready !== 1'b1 || s_if.read_data !== 32'h12345678 || s_if.status !== RGGEN_SLAVE_ERROR) begin
            n_mismatched++;
            $display("[TB] FAIL read_response: got rdy=%b d=%h st=%h expected rdy=1 d=12345678 st=2", s_if.ready, s_if.read_data, s_if.status);
        end
        tick();
        n_compared++;
        if (s_if.ready !== 1'b0 || s_if.read_data !== 32'h12345678 || s_if.status !== RGGEN_SLAVE_ERROR) begin
            n_mismatched++;
            $display("[TB] FAIL read_hold: got rdy=%b d=%h st=%h expected rdy=0 d=12345678 st=2", s_if.ready, s_if.read_data, s_if.status);
        end
    endtask

    task automatic test_back_to_back();
        int start_hs;
        start_hs = n_handshakes;
        s_if.valid   = 1'b1;
        s_if.access  = RGGEN_READ;
        s_if.address = 16'h0030;
        tick();
        n_compared++;
        if (m_if.valid !== 1'b1 || m_if.address !== 16'h0030) begin n_mismatched++; $display("[TB] FAIL b2b_first_req: got mv=%b a=%h expected mv=1 a=0030", m_if.valid, m_if.address); end
        m_if.ready     = 1'b1;
        m_if.read_data = 32'h11110000;
        tick();
        m_if.ready   = 1'b0;
        s_if.address = 16'h0034;
        n_compared++;
        if (s_if.ready !== 1'b1 || s_if.read_data !== 32'h11110000) begin n_mismatched++; $display("[TB] FAIL b2b_first_rsp: got rdy=%b d=%h expected rdy=1 d=11110000", s_if.ready, s_if.read_data); end
        tick();
        n_compared++;
        if (m_if.valid !== 1'b0 || s_if.ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL b2b_idle_gap: got mv=%b sr=%b expected mv=0 sr=0", m_if.valid, s_if.ready); end
        tick();
        s_if.valid = 1'b0;
        n_compared++;
        if (m_if.valid !== 1'b1 || m_if.address !== 16'h0034) begin n_mismatched++; $display("[TB] FAIL b2b_second_req: got mv=%b a=%h expected mv=1 a=0034", m_if.valid, m_if.address); end
        m_if.ready     = 1'b1;
        m_if.read_data = 32'h22220000;
        tick();
        m_if.ready = 1'b0;
        n_compared++;
        if (s_if.ready !== 1'b1 || s_if.read_data !== 32'h22220000) begin n_mismatched++; $display("[TB] FAIL b2b_second_rsp: got rdy=%b d=%h expected rdy=1 d=22220000", s_if.ready, s_if.read_data); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_compared++;
            if (m_if.valid !== 1'b0 || s_if.ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL b2b_quiet_%0d: got mv=%b sr=%b expected 0/0", i, m_if.valid, s_if.ready); end
        end
        n_compared++;
        if (n_handshakes - start_hs !== 2) begin n_mismatched++; $display("[TB] FAIL b2b_count: got %0d expected 2", n_handshakes - start_hs); end
    endtask

    task automatic test_stray_ready();
        // Stray ready while idle.
        m_if.ready     = 1'b1;
        m_if.status    = RGGEN_DECODE_ERROR;
        m_if.read_data = 32'h00000BAD;
        tick();
        tick();
        n_compared++;
        if (s_if.ready !== 1'b0 || m_if.valid !== 1'b0 || s_if.read_data !== 32'h22220000 || s_if.status !== RGGEN_OKAY) begin
            n_mismatched++;
            $display("[TB] FAIL stray_idle: got sr=%b mv=%b d=%h st=%h expected 0/0/22220000/0", s_if.ready, m_if.valid, s_if.read_data, s_if.status);
        end
        // Ready held through REQUEST and into RESPONSE/IDLE.
        m_if.status    = RGGEN_OKAY;
        m_if.read_data = 32'h0C0C0C0C;
        s_if.valid     = 1'b1;
        s_if.address   = 16'h0050;
        tick();
        s_if.valid = 1'b0;
        tick();
        m_if.status    = RGGEN_DECODE_ERROR;
        m_if.read_data = 32'h00000BAD;
        n_compared++;
        if (s_if.ready !== 1'b1 || s_if.read_data !== 32'h0C0C0C0C) begin n_mismatched++; $display("[TB] FAIL stray_rsp: got rdy=%b d=%h expected rdy=1 d=0c0c0c0c", s_if.ready, s_if.read_data); end
        tick();
        n_compared++;
        if (s_if.ready !== 1'b0 || s_if.read_data !== 32'h0C0C0C0C || s_if.status !== RGGEN_OKAY) begin
            n_mismatched++;
            $display("[TB] FAIL stray_after_rsp: got sr=%b d=%h st=%h expected 0/0c0c0c0c/0", s_if.ready, s_if.read_data, s_if.status);
        end
        tick();
        n_compared++;
        if (s_if.ready !== 1'b0 || m_if.valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL stray_quiet: got sr=%b mv=%b expected 0/0", s_if.ready, m_if.valid); end
        m_if.ready     = 1'b0;
        m_if.status    = RGGEN_OKAY;
        m_if.read_data = 32'h0;
    endtask

    task automatic test_async_reset();
        s_if.valid      = 1'b1;
        s_if.access     = RGGEN_WRITE;
        s_if.address    = 16'h0060;
        s_if.write_data = 32'h01020304;
        s_if.strobe     = 4'h1;
        tick();
        s_if.valid = 1'b0;
        n_compared++;
        if (m_if.valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL arst_pre: got %b expected 1", m_if.valid); end
        #2;
        rst_n = 1'b0;
        #1;
        n_compared++;
        if (m_if.valid !== 1'b0 || m_if.address !== 16'h0000 || m_if.access !== RGGEN_READ) begin
            n_mismatched++;
            $display("[TB] FAIL arst_immediate: got mv=%b a=%h acc=%h expected 0/0000/0", m_if.valid, m_if.address, m_if.access);
        end
        #3;
        rst_n = 1'b1;
        tick();
        n_compared++;
        if (s_if.ready !== 1'b0 || m_if.valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL arst_no_rsp: got sr=%b mv=%b expected 0/0", s_if.ready, m_if.valid); end
        s_if.valid      = 1'b1;
        s_if.address    = 16'h0040;
        s_if.write_data = 32'hCAFEF00D;
        s_if.strobe     = 4'h3;
        tick();
        s_if.valid = 1'b0;
        n_compared++;
        if (m_if.valid !== 1'b1 || m_if.address !== 16'h0040 || m_if.write_data !== 32'hCAFEF00D || m_if.strobe !== 4'h3) begin
            n_mismatched++;
            $display("[TB] FAIL arst_new_req: got mv=%b a=%h d=%h s=%h expected 1/0040/cafef00d/3", m_if.valid, m_if.address, m_if.write_data, m_if.strobe);
        end
        m_if.ready = 1'b1;
        tick();
        m_if.ready = 1'b0;
        n_compared++;
        if (s_if.ready !== 1'b1 || s_if.status !== RGGEN_OKAY) begin n_mismatched++; $display("[TB] FAIL arst_new_rsp: got rdy=%b st=%h expected 1/0", s_if.ready, s_if.status); end
        tick();
    endtask

`ifdef RGGEN_BUS_SLICE_TIMEOUT_EN
    task automatic test_timeout();
        // Expiry with no downstream answer.
        s_if.valid   = 1'b1;
        s_if.access  = RGGEN_READ;
        s_if.address = 16'h0070;
        tick();
        s_if.valid = 1'b0;
        for (int i = 1; i < 8; i++) begin
            tick();
        end
        n_compared++;
        if (m_if.valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL timeout_cycle8: got %b expected 1", m_if.valid); end
        tick();
        n_compared++;
        if (m_if.valid !== 1'b0 || s_if.ready !== 1'b1 || s_if.status !== RGGEN_SLAVE_ERROR || s_if.read_data !== 32'h0) begin
            n_mismatched++;
            $display("[TB] FAIL timeout_expire: got mv=%b sr=%b st=%h d=%h expected 0/1/2/0", m_if.valid, s_if.ready, s_if.status, s_if.read_data);
        end
        tick();
        // Ready on the last allowed cycle completes normally.
        s_if.valid = 1'b1;
        tick();
        s_if.valid = 1'b0;
        for (int i = 1; i < 8; i++) begin
            tick();
        end
        m_if.ready     = 1'b1;
        m_if.status    = RGGEN_OKAY;
        m_if.read_data = 32'h000055AA;
        tick();
        m_if.ready = 1'b0;
        n_compared++;
        if (s_if.ready !== 1'b1 || s_if.status !== RGGEN_OKAY || s_if.read_data !== 32'h000055AA) begin
            n_mismatched++;
            $display("[TB] FAIL timeout_race: got sr=%b st=%h d=%h expected 1/0/000055aa", s_if.ready, s_if.status, s_if.read_data);
        end
        tick();
    endtask
`endif

    initial begin
        n_compared      = 0;
        n_mismatched    = 0;
        n_handshakes    = 0;
        rst_n           = 1'b0;
        s_if.valid      = 1'b0;
        s_if.access     = RGGEN_READ;
        s_if.address    = '0;
        s_if.write_data = '0;
        s_if.strobe     = '0;
        m_if.ready      = 1'b0;
        m_if.status     = RGGEN_OKAY;
        m_if.read_data  = '0;
        #12;
        test_reset();
        test_write();
        test_read_slow();
        test_back_to_back();
        test_stray_ready();
        test_async_reset();
`ifdef RGGEN_BUS_SLICE_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
